apb_master_arbiter: RTL
=======================

# apb_master_arbiter

APB master that shares one APB slave, such as the 32-bit register-file slave, between `NumReq` local requesters. Each requester posts a single read or write on a simple req/done interface. A round-robin arbiter picks one request and the block runs the APB SETUP/ACCESS sequence for it. It returns read data and the slave error to that requester. The block sits between bus-side clients (DMA, CPU port, test port) and the APB slave's `p_*` pins.

## Interface
Parameters:
- `NumReq`, 2: number of requesters, 2..8.
- `AddrBits`, 32: APB address width; must match the slave.
- `TimeoutCycles`, 16: ACCESS-phase wait limit, used only with `APB_ARB_TIMEOUT_EN`.

Ports:
- `p_clk`  in  1: the one clock; all logic is on its rising edge.
- `p_resetn`  in  1: asynchronous, active-low reset.
- `req`  in  NumReq: request, one bit per requester.
- `req_write`  in  NumReq: 1 = write, 0 = read.
- `req_addr`  in  NumReq x AddrBits: address per requester.
- `req_wdata`  in  NumReq x 32: write data per requester.
- `req_strb`  in  NumReq x 4: byte strobes per requester.
- `done`  out  NumReq: one-cycle completion pulse to the owning requester.
- `rsp_rdata`  out  32: read data, valid while any `done` bit is high.
- `rsp_err`  out  1: transfer error, valid while any `done` bit is high.
- `p_addr`  out  AddrBits: APB address.
- `p_sel`  out  1: APB select.
- `p_enable`  out  1: APB enable.
- `p_write`  out  1: APB write.
- `p_wdata`  out  32: APB write data.
- `p_strb`  out  4: APB byte strobes.
- `p_rdata`  in  32: APB read data.
- `p_ready`  in  1: APB ready.
- `p_slverr`  in  1: APB slave error.

## Operation
- FSM states:
  - IDLE: `p_sel`=0, `p_enable`=0.
  - SETUP: `p_sel`=1, `p_enable`=0.
  - ACCESS: `p_sel`=1, `p_enable`=1.
- IDLE -> SETUP when any `req` bit is high.
  - On that edge, the winner index and its write/addr/wdata/strb are registered into the `p_*` outputs.
- SETUP -> ACCESS unconditionally, after one cycle.
- ACCESS -> IDLE on the edge where `p_ready`=1. Otherwise the FSM stays in ACCESS with all `p_*` outputs held stable.
- Completion is combinational in the cycle where the FSM is in ACCESS and `p_ready`=1:
  - `done[owner]`=1.
  - `rsp_rdata` = `p_rdata` for reads, 0 for writes.
  - `rsp_err` = `p_slverr`.
  - All other cycles: `done`=0, `rsp_rdata`=0, `rsp_err`=0.
- Requester rules:
  - Hold `req` and all of its fields stable from assertion until its `done` pulse.
  - Deassert `req` in the cycle after `done`, or keep it high to issue a new transfer with new fields.
  - Deasserting `req` early is illegal; the latched transfer completes regardless.
- Reads drive `p_strb`=4'b0000 and `p_wdata`=0.
- A write with all-zero strobes is passed through unchanged; the slave ignores it.
- Arbitration:
  - Round-robin pointer `rr_ptr`, width $clog2(NumReq).
  - The winner is the first set `req` bit at index `rr_ptr`, `rr_ptr`+1, ... with wrap modulo `NumReq`.
  - On grant, `rr_ptr` <= winner+1; this wraps to 0 when winner = `NumReq`-1.
  - Requests arriving while the FSM is in SETUP or ACCESS wait for the next IDLE cycle.
- Reset:
  - All outputs go to 0: `p_sel`, `p_enable`, `p_write`, `p_addr`, `p_wdata`, `p_strb`, `done`, `rsp_rdata`, `rsp_err`.
  - FSM goes to IDLE and `rr_ptr` to 0.
  - A reset asserted mid-transfer aborts it immediately (asynchronously) with no `done` pulse. The requester reissues the request after reset.

## Timing
- Minimum 3 cycles per transfer (IDLE, SETUP, ACCESS) against a zero-wait slave. Each wait state adds one cycle.
- Latency: `req` sampled high in IDLE at edge N -> SETUP in cycle N..N+1 -> `done` in cycle N+1..N+2.
- There is always at least one IDLE cycle between transfers, so `p_sel` deasserts between transfers.
- `p_*` outputs are registered. `done`, `rsp_rdata` and `rsp_err` are combinational from the FSM state, `p_ready`, `p_rdata` and `p_slverr`.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on SETUP and increments each ACCESS cycle with `p_ready`=0.
  - When it reaches `TimeoutCycles`, the transfer is forced to complete: `done[owner]`=1, `rsp_err`=1, `rsp_rdata`=0, then FSM -> IDLE.
  - If `p_ready` is high in that same cycle, the normal completion takes precedence.
- `APB_ARB_TIMEOUT_EN` undefined: no counter is built, and ACCESS waits for `p_ready` indefinitely.

## Structure
- Package `apb_pkg`:
  - `apb_state_e`, the enum IDLE/SETUP/ACCESS.
  - `APB_DATA_W`=32 and `APB_STRB_W`=4.
  - Typedef `apb_req_t`, a struct of write, addr, wdata and strb.
- Sub-module `rr_arbiter`, #(NumReq):
  - Inputs `req` and `rr_ptr`; outputs `winner` index and `any_req`.
  - Purely combinational.
  - Instantiated once in the top.

## Test plan
- Single write, requester 0, addr 0x04, wdata 0xDEADBEEF, strb 4'hF -> SETUP then ACCESS; `done[0]` pulses 2 cycles after `req` is sampled; `rsp_err`=0; a read back at 0x04 returns 0xDEADBEEF.
- Partial write, strb 4'b0011 with wdata 0x0000CAFE over 0xDEADBEEF -> readback 0xDEADCAFE.
- Out-of-range address, where the slave asserts `p_slverr` -> `done` with `rsp_err`=1; a subsequent valid read returns the old data.
- Both requesters hold `req` continuously -> grants alternate 0, 1, 0, 1; each `done` pulse is 3 cycles apart; with `req` raised simultaneously after reset, requester 0 wins first.
- Slave with 2 wait states -> `p_*` outputs stable throughout ACCESS; `done` 4 cycles after grant.
- With `APB_ARB_TIMEOUT_EN` defined and `TimeoutCycles`=16, `p_ready` tied low -> `done`=1 with `rsp_err`=1 after 16 ACCESS cycles, then IDLE.
- Assert reset during ACCESS -> all outputs 0 immediately; no `done` pulse.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg: shared FSM states, bus widths and request record for the APB master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  localparam int APB_DATA_W     = 32;
  localparam int APB_STRB_W     = 4;
  localparam int APB_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Address is carried at the widest supported width; the top narrows it.
  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_MAX_W-1:0] addr;
    logic [APB_DATA_W-1:0]     wdata;
    logic [APB_STRB_W-1:0]     strb;
  } apb_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick starting at rr_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NumReq = 2
) (
  input  logic [NumReq-1:0]         req,
  input  logic [$clog2(NumReq)-1:0] rr_ptr,
  output logic [$clog2(NumReq)-1:0] winner,
  output logic                      any_req
);

  localparam int PtrW = $clog2(NumReq);
  localparam logic [PtrW:0] c_num_req = (PtrW+1)'(NumReq);

  logic [PtrW:0] w_idx;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    w_idx   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      w_idx = {1'b0, rr_ptr} + (PtrW+1)'(i);
      if (w_idx >= c_num_req) w_idx = w_idx - c_num_req;
      if (req[w_idx[PtrW-1:0]]) begin
        winner  = w_idx[PtrW-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter: round-robin shared APB master; APB_ARB_TIMEOUT_EN adds an
// ACCESS-phase timeout.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int AddrBits      = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                                  p_clk,
  input  logic                                  p_resetn,
  input  logic [NumReq-1:0]                     req,
  input  logic [NumReq-1:0]                     req_write,
  input  logic [NumReq-1:0][AddrBits-1:0]       req_addr,
  input  logic [NumReq-1:0][APB_DATA_W-1:0]     req_wdata,
  input  logic [NumReq-1:0][APB_STRB_W-1:0]     req_strb,
  output logic [NumReq-1:0]                     done,
  output logic [APB_DATA_W-1:0]                 rsp_rdata,
  output logic                                  rsp_err,
  output logic [AddrBits-1:0]                   p_addr,
  output logic                                  p_sel,
  output logic                                  p_enable,
  output logic                                  p_write,
  output logic [APB_DATA_W-1:0]                 p_wdata,
  output logic [APB_STRB_W-1:0]                 p_strb,
  input  logic [APB_DATA_W-1:0]                 p_rdata,
  input  logic                                  p_ready,
  input  logic                                  p_slverr
);

  localparam int PtrW = $clog2(NumReq);

  apb_state_e      r_state;
  logic [PtrW-1:0] r_rr_ptr;
  logic [PtrW-1:0] r_owner;
  logic [PtrW-1:0] w_winner;
  logic            w_any_req;
  logic            w_timeout;
  logic            w_complete;
  apb_req_t        w_sel;

  rr_arbiter #(.NumReq(NumReq)) u_rr_arbiter (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  always_comb begin
    w_sel.write = req_write[w_winner];
    w_sel.addr  = APB_ADDR_MAX_W'(req_addr[w_winner]);
    w_sel.wdata = req_wdata[w_winner];
    w_sel.strb  = req_strb[w_winner];
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  assign w_timeout = (r_state == ACCESS) && (r_wait_cnt == 8'(TimeoutCycles));
`else
  assign w_timeout = 1'b0;
`endif

  // A ready slave wins over a timeout landing in the same cycle.
  assign w_complete = (r_state == ACCESS) && (p_ready || w_timeout);

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      p_sel    <= 1'b0;
      p_enable <= 1'b0;
      p_write  <= 1'b0;
      p_addr   <= '0;
      p_wdata  <= '0;
      p_strb   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state  <= SETUP;
            r_owner  <= w_winner;
            r_rr_ptr <= (w_winner == PtrW'(NumReq - 1)) ? '0 : w_winner + PtrW'(1);
            p_sel    <= 1'b1;
            p_write  <= w_sel.write;
            p_addr   <= AddrBits'(w_sel.addr);
            p_wdata  <= w_sel.write ? w_sel.wdata : '0;
            p_strb   <= w_sel.write ? w_sel.strb  : '0;
          end
        end
        SETUP: begin
          r_state  <= ACCESS;
          p_enable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (w_complete) begin
            r_state  <= IDLE;
            p_sel    <= 1'b0;
            p_enable <= 1'b0;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        default: begin
          r_state  <= IDLE;
          p_sel    <= 1'b0;
          p_enable <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    done      = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (w_complete) begin
      done[r_owner] = 1'b1;
      rsp_err       = p_ready ? p_slverr : 1'b1;
      if (p_ready && !p_write) rsp_rdata = p_rdata;
    end
  end

endmodule

`default_nettype wire
